// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between a word fetch requester and a data
// (load/store) requester. Each access is serialised into per-byte RAM cycles;
// loads are reassembled little-endian and extended, and completion is a
// one-cycle pulse on the granted side.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // Fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_ready,
  output logic [31:0] if_data,
  // Data side
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_tag,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [2:0]  d_done_tag,
  // RAM port
  output logic [31:0] ram_addr,
  output logic        ram_writing,
  output logic [7:0]  ram_data,
  input  logic [7:0]  ram_loaded_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q;
  logic        sel_data_q;   // current access belongs to the data side
  logic        last_data_q;  // most recent grant went to the data side
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [2:0]  tag_q;
  logic [2:0]  n_q;
  logic [2:0]  cnt_q;        // edges seen since the accepting edge, minus one

  logic        flush_abort;
  logic        can_accept;
  logic        fetch_ok;
  logic        take_data;
  logic        take_fetch;
  logic [2:0]  n_new;
  logic [31:0] addr_new;
  logic [2:0]  cnt_inc;
  logic [31:0] addr_next;
  logic [1:0]  cap_idx;
  logic [31:0] cap_buf;
  logic [31:0] ext_data;
  logic [7:0]  wbyte_next;

  // Grant decision: a fetch abort frees the port on the same edge for a data request.
  always_comb begin
    flush_abort = (state_q == StRead) && !sel_data_q && flush;
    can_accept  = (state_q == StIdle) || flush_abort;
    fetch_ok    = if_req && !flush;
    take_data   = can_accept && d_req && (!fetch_ok || !last_data_q);
    take_fetch  = can_accept && fetch_ok && !take_data;
    unique case (d_size)
      2'd0:    n_new = 3'd1;
      2'd1:    n_new = 3'd2;
      default: n_new = 3'd4;
    endcase
    if (take_fetch) n_new = 3'd4;
    addr_new = take_data ? d_addr : if_addr;
  end

  // Per-byte address/data sequencing and read-data assembly with extension.
  always_comb begin
    cnt_inc    = cnt_q + 3'd1;
    addr_next  = addr_q + {29'd0, cnt_inc};
    wbyte_next = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
    // Byte captured on this edge is the one addressed two edges earlier.
    cap_idx    = cnt_q[1:0] - 2'd1;
    cap_buf    = rbuf_q;
    cap_buf[{cap_idx, 3'b000} +: 8] = ram_loaded_data;
    unique case (size_q)
      2'd0:    ext_data = {{24{signed_q & cap_buf[7]}}, cap_buf[7:0]};
      2'd1:    ext_data = {{16{signed_q & cap_buf[15]}}, cap_buf[15:0]};
      default: ext_data = cap_buf;
    endcase
  end

  // Access FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_data_q  <= 1'b0;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      tag_q       <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      if_ready    <= 1'b0;
      if_data     <= '0;
      d_done      <= 1'b0;
      d_rdata     <= '0;
      d_done_tag  <= '0;
      ram_addr    <= '0;
      ram_writing <= 1'b0;
      ram_data    <= '0;
      busy        <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_done   <= 1'b0;
      if (take_data || take_fetch) begin
        sel_data_q  <= take_data;
        last_data_q <= take_data;
        addr_q      <= addr_new;
        wdata_q     <= take_data ? d_wdata : 32'd0;
        size_q      <= take_data ? d_size : 2'd2;
        signed_q    <= take_data && d_signed;
        tag_q       <= d_tag;
        n_q         <= n_new;
        cnt_q       <= '0;
        rbuf_q      <= '0;
        ram_addr    <= addr_new;
        busy        <= 1'b1;
        if (take_data && d_write) begin
          state_q     <= StWrite;
          ram_writing <= 1'b1;
          ram_data    <= d_wdata[7:0];
        end else begin
          state_q     <= StRead;
          ram_writing <= 1'b0;
          ram_data    <= '0;
        end
      end else if (flush_abort) begin
        state_q  <= StIdle;
        ram_addr <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StRead: begin
            cnt_q    <= cnt_inc;
            ram_addr <= (cnt_inc < n_q) ? addr_next : 32'd0;
            if (cnt_q != 3'd0) rbuf_q <= cap_buf;
            if (cnt_q == n_q) begin
              state_q <= StDone;
              if (sel_data_q) begin
                d_done     <= 1'b1;
                d_rdata    <= ext_data;
                d_done_tag <= tag_q;
              end else begin
                if_ready <= 1'b1;
                if_data  <= cap_buf;
              end
            end
          end
          StWrite: begin
            cnt_q <= cnt_inc;
            if (cnt_inc < n_q) begin
              ram_addr <= addr_next;
              ram_data <= wbyte_next;
            end else begin
              ram_addr    <= '0;
              ram_data    <= '0;
              ram_writing <= 1'b0;
              state_q     <= StDone;
              d_done      <= 1'b1;
              d_rdata     <= '0;
              d_done_tag  <= tag_q;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of data accesses plus hand-written
// sequences for reset, fetch, arbitration and flush.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_tag;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [2:0]  d_done_tag;
  logic [31:0] ram_addr;
  logic        ram_writing;
  logic [7:0]  ram_data;
  logic [7:0]  ram_loaded_data;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_ready(if_ready), .if_data(if_data),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_tag(d_tag),
    .d_done(d_done), .d_rdata(d_rdata), .d_done_tag(d_done_tag),
    .ram_addr(ram_addr), .ram_writing(ram_writing), .ram_data(ram_data),
    .ram_loaded_data(ram_loaded_data), .busy(busy)
  );

  // RAM model: read data valid one cycle after the address.
  logic [7:0] mem [0:1023];
  logic       clr;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      ram_loaded_data <= 8'h00;
    end else begin
      if (ram_writing) mem[ram_addr[9:0]] <= ram_data;
      ram_loaded_data <= mem[ram_addr[9:0]];
    end
  end

  int if_ready_cnt = 0;
  int d_done_cnt = 0;
  always @(posedge clk) begin
    if (if_ready) if_ready_cnt++;
    if (d_done) d_done_cnt++;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One data access; returns the edge index (E0 = 0) of the completion pulse.
  task automatic do_data(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [2:0] tg,
                         output int lat, output logic [31:0] rd, output logic [2:0] rt);
    d_write = wr; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd; d_tag = tg;
    d_req = 1'b1;
    lat = -1; rd = '0; rt = '0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (d_done) begin
        lat = e; rd = d_rdata; rt = d_done_tag;
        break;
      end
    end
    d_req = 1'b0;
    tick();
  endtask

  // Word fetch; checks the byte address sequence and returns the pulse edge.
  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] data);
    if_addr = a;
    if_req  = 1'b1;
    lat = -1; data = '0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e < 4) check($sformatf("fetch_addr%0d", e), ram_addr, a + e);
      if (if_ready) begin
        lat = e; data = if_data;
        break;
      end
    end
    if_req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  tag;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [2:0]  rt;
    int          cnt;
    logic        wr_seen;
    logic        side;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0513, 3'd0, 32'h0000_0000, 4};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 3'd5, 32'h0000_0000, 4};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0107, 32'h1234_5678, 3'd2, 32'h0000_0000, 1};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'h0000_0080, 3'd1, 32'h0000_0000, 1};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_007F, 3'd3, 32'h0000_0000, 1};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0, 3'd4, 32'hFFFF_FF80, 2};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0, 3'd4, 32'h0000_0080, 2};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0020, 32'h0, 3'd7, 32'h0000_7F80, 3};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0020, 32'h0, 3'd0, 32'h0000_7F80, 3};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 3'd6, 32'hDEAD_BEEF, 5};
    vecs[10] = '{1'b0, 2'd3, 1'b1, 32'h0000_0104, 32'h0, 3'd1, 32'h7800_0000, 5};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 3'd2, 32'hFFFF_DEAD, 3};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h0000_0107, 32'h0, 3'd3, 32'h0000_0078, 2};
    vecs[13] = '{1'b1, 2'd1, 1'b1, 32'h0000_01FF, 32'hAAAA_8001, 3'd4, 32'h0000_0000, 2};
    vecs[14] = '{1'b0, 2'd1, 1'b1, 32'h0000_01FF, 32'h0, 3'd5, 32'hFFFF_8001, 3};

    rst = 1'b1; clr = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_size = '0; d_signed = 1'b0;
    d_addr = '0; d_wdata = '0; d_tag = '0;
    tick(); tick();
    rst = 1'b0; clr = 1'b0;

    check("rst_if_data", if_data, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_flags", {23'd0, if_ready, d_done, d_done_tag, ram_writing, busy},
          32'h0);
    check("rst_ram_data", {24'd0, ram_data}, 32'h0);

    // Table of data accesses.
    for (int i = 0; i < 15; i++) begin
      do_data(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, vecs[i].tag,
              lat, rd, rt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_tag", i), {29'd0, rt}, {29'd0, vecs[i].tag});
    end
    check("mem_sw", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]}, 32'hDEADBEEF);
    check("mem_sb", {mem[10'h107], mem[10'h106], mem[10'h105], mem[10'h104]}, 32'h78000000);
    check("mem_sh_wrap", {16'd0, mem[10'h200], mem[10'h1FF]}, 32'h00008001);

    // Reset held two cycles in the middle of a word store.
    d_write = 1'b1; d_size = 2'd2; d_signed = 1'b0;
    d_addr = 32'h1F0; d_wdata = 32'hCAFEF00D; d_tag = 3'd7; d_req = 1'b1;
    tick(); tick();
    check("midsw_writing", {31'd0, ram_writing}, 32'd1);
    cnt = d_done_cnt;
    rst = 1'b1; d_req = 1'b0;
    tick();
    check("midsw_rst_ram_addr", ram_addr, 32'h0);
    check("midsw_rst_flags", {25'd0, if_ready, d_done, ram_writing, busy, ram_data == 8'h0,
                              d_done_tag == 3'd0, d_rdata == 32'h0}, 32'h7);
    tick();
    rst = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_seen = wr_seen | ram_writing;
    end
    check("midsw_no_write", {31'd0, wr_seen}, 32'd0);
    check("midsw_bytes23", {16'd0, mem[10'h1F3], mem[10'h1F2]}, 32'h0);
    check("midsw_no_done", d_done_cnt, cnt);

    // Fetch after reset.
    do_fetch(32'h0, lat, rd);
    check("fetch_latency", lat, 5);
    check("fetch_data", rd, 32'h00000513);

    // Arbitration: both sides request continuously from reset.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    if_addr = 32'h0;
    d_write = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h100; d_tag = 3'd6;
    if_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      lat = -1; side = 1'b0; rd = '0;
      for (int e = 0; e < 20; e++) begin
        tick();
        if (d_done || if_ready) begin
          lat = e; side = d_done; rd = d_done ? d_rdata : if_data;
          break;
        end
      end
      check($sformatf("arb%0d_seen", g), {31'd0, lat >= 0}, 32'd1);
      check($sformatf("arb%0d_side", g), {31'd0, side}, {31'd0, (g % 2) == 0});
      check($sformatf("arb%0d_data", g), rd, ((g % 2) == 0) ? 32'hDEADBEEF : 32'h00000513);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Flush at E2 of a fetch with nothing else pending.
    cnt = if_ready_cnt;
    if_addr = 32'h0; if_req = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; if_req = 1'b0;
    check("flushA_ram_addr", ram_addr, 32'h0);
    check("flushA_busy", {31'd0, busy}, 32'd0);
    repeat (8) tick();
    check("flushA_no_ready", if_ready_cnt, cnt);

    // Flush at E2 of a fetch while a word load is pending.
    cnt = if_ready_cnt;
    if_addr = 32'h0; if_req = 1'b1;
    tick();
    d_write = 1'b0; d_size = 2'd2; d_signed = 1'b0; d_addr = 32'h100; d_tag = 3'd6;
    d_req = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; if_req = 1'b0;
    check("flushB_ram_addr", ram_addr, 32'h100);
    lat = -1; rd = '0; rt = '0;
    for (int e = 1; e < 20; e++) begin
      tick();
      if (d_done) begin
        lat = e; rd = d_rdata; rt = d_done_tag;
        break;
      end
    end
    d_req = 1'b0;
    tick();
    check("flushB_latency", lat, 5);
    check("flushB_rdata", rd, 32'hDEADBEEF);
    check("flushB_tag", {29'd0, rt}, 32'd6);
    repeat (4) tick();
    check("flushB_no_ready", if_ready_cnt, cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
